// File: rtl/dff_r.sv
// dff_r
//   Resettable rising-edge D flip-flop, built as a master-slave pair of
//   D latches per bit. It is the storage cell behind the registers, counters
//   and shift registers elsewhere in the design. WIDTH and RESET_VALUE widen
//   it into a plain register while keeping the same port list.
//
// Ports
//   clk      in   1      clock; q updates only on the rising edge
//   reset_n  in   1      asynchronous active-low reset, overrides clk
//   d        in   WIDTH  data captured on the rising edge
//   q        out  WIDTH  registered output
//
// Per bit:
//   master latch  transparent while clk=0, holds d across the rising edge
//   slave latch   transparent while clk=1, presents the held master value
// Because the two latches are never transparent together, there is no
// combinational path from d to q.
//
// Reset forces both latches. Forcing the slave clears q at once, without
// waiting for a clock edge. Forcing the master as well matters when reset is
// released while clk=1. In that case the slave is still transparent, so an
// unreset master would leak data captured before reset onto q. Releasing
// reset at the same instant as a rising edge leaves the master opaque and
// still holding RESET_VALUE. That edge is therefore ignored, and the next
// rising edge is the first one to capture d.

module dff_r #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic mst_q;
        logic slv_q;

        always_latch begin
            if (!reset_n) begin
                mst_q <= RESET_VALUE[gi];
            end else if (!clk) begin
                mst_q <= d[gi];
            end
        end

        always_latch begin
            if (!reset_n) begin
                slv_q <= RESET_VALUE[gi];
            end else if (clk) begin
                slv_q <= mst_q;
            end
        end

        assign q[gi] = slv_q;
    end

endmodule

// File: tb/tb_dff_r.sv
// tb_dff_r
//   Bench for dff_r. It drives two instances: the default 1-bit cell, and an
//   8-bit register with reset value 8'hA5.
//   The first part is a directed timeline. It uses literal expectations for
//   reset dominance, release-then-capture, tracking, asynchronous clear,
//   coincident release, and the wide reset value.
//   The second part uses random data and random reset activity against a
//   simple rule model:
//     - q is the reset value whenever reset_n is low;
//     - otherwise q is the d seen at the last rising edge where reset_n was 1.

module tb_dff_r;

    localparam logic       RV_A = 1'b0;
    localparam logic [7:0] RV_B = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       d_a;
    logic       q_a;
    logic       rst_b;
    logic [7:0] d_b;
    logic [7:0] q_b;

    logic       exp_a;
    logic [7:0] exp_b;
    logic       chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dff_r u_dut_a (
        .clk     (clk),
        .reset_n (rst_a),
        .d       (d_a),
        .q       (q_a)
    );

    dff_r #(
        .WIDTH       (8),
        .RESET_VALUE (RV_B)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (rst_b),
        .d       (d_b),
        .q       (q_b)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Model compare: checks once at every falling edge, and again shortly
    // after every rising edge (after any mid-cycle reset event).
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_a_neg", {7'b0, q_a}, {7'b0, exp_a});
                check("model_b_neg", q_b, exp_b);
            end
            @(posedge clk);
            #3;
            if (chk_en) begin
                check("model_a_pos", {7'b0, q_a}, {7'b0, exp_a});
                check("model_b_pos", q_b, exp_b);
            end
        end
    end

    initial begin
        int r;
        // Directed timeline. Rising edges occur at 5, 15, 25, ... ns.
        rst_a = 1'b0;
        d_a   = 1'b0;
        rst_b = 1'b0;
        d_b   = 8'h3C;
        exp_a = RV_A;
        exp_b = RV_B;
        #2  d_a = 1'b1;
        #1  check("rst_hold_a_t3", {7'b0, q_a}, 8'h00);
            check("rst_val_b_t3", q_b, 8'hA5);
        #3  check("rst_edge5_a", {7'b0, q_a}, 8'h00);
        #1  begin rst_a = 1'b1; d_a = 1'b1; end
        #5  check("release_wait_t12", {7'b0, q_a}, 8'h00);
        #4  check("capture_t16", {7'b0, q_a}, 8'h01);
        #1  d_a = 1'b0;
        #3  check("hold_t20", {7'b0, q_a}, 8'h01);
        #2  d_a = 1'b1;
        #4  check("track_t26", {7'b0, q_a}, 8'h01);
        #1  rst_a = 1'b0;
        #1  check("async_clr_t28", {7'b0, q_a}, 8'h00);
        #8  check("clr_thru_edge_t36", {7'b0, q_a}, 8'h00);
        @(posedge clk);
        rst_a = 1'b1;
        #1  check("coincident_edge", {7'b0, q_a}, 8'h00);
        @(posedge clk);
        #1  check("coincident_next", {7'b0, q_a}, 8'h01);
        #2  rst_b = 1'b1;
        #3  check("wide_release_wait", q_b, 8'hA5);
        #5  check("wide_capture", q_b, 8'h3C);

        exp_a  = 1'b1;
        exp_b  = 8'h3C;
        chk_en = 1'b1;

        // Randomized phase, checked by the compare process above.
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            #1;
            rst_a = ($urandom_range(0, 4) != 0);
            rst_b = ($urandom_range(0, 4) != 0);
            if (!rst_a) exp_a = RV_A;
            if (!rst_b) exp_b = RV_B;
            d_a = 1'($urandom);
            d_b = 8'($urandom);

            @(posedge clk);
            #1;
            exp_a = rst_a ? d_a : RV_A;
            exp_b = rst_b ? d_b : RV_B;

            // While clk is high: sometimes assert reset, sometimes release it.
            #1;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rst_a = 1'b0;
                exp_a = RV_A;
            end else if (r < 4 && !rst_a) begin
                rst_a = 1'b1;
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rst_b = 1'b0;
                exp_b = RV_B;
            end else if (r < 4 && !rst_b) begin
                rst_b = 1'b1;
            end

            // Change d between edges; q must not follow it.
            #2;
            d_a = 1'($urandom);
            d_b = 8'($urandom);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
